// File: rtl/prefetcher_addr_gen.sv
// Stride prefetch address generator: trains on demand read addresses, and once a
// stride is confirmed issues block-aligned AXI AR prefetches ahead of the demand stream.
module prefetcher_addr_gen #(
  parameter int BA_ADDR_SIZE         = 64,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int LOG_QUEUE_SIZE       = 6
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      reqValid,
  input  logic [BA_ADDR_SIZE-1:0]   reqAddr,
  input  logic [LOG_QUEUE_SIZE:0]   outstandingReqCnt,
  input  logic                      almostFull,
  input  logic [LOG_QUEUE_SIZE:0]   prefetchWindow,
  input  logic                      arReady,
  output logic                      arValid,
  output logic [BA_ADDR_SIZE-1:0]   arAddr,
  output logic                      qWrReq,
  output logic [BA_ADDR_SIZE-1:0]   qAddr,
  output logic                      flush,
  output logic                      armed,
  output logic [1:0]                dbg_state
);

  // AR channel: arValid/arAddr are held stable from issue until the cycle
  // arValid && arReady is sampled high; arValid drops the cycle after.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    ARMED = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [BA_ADDR_SIZE-1:0] ALIGN_MASK =
    {BA_ADDR_SIZE{1'b1}} << LOG_BLOCK_DATA_BYTES;

  state_e                  state_q, state_d;
  logic [BA_ADDR_SIZE-1:0] last_addr_q, last_addr_d;
  logic [BA_ADDR_SIZE-1:0] prev_delta_q, prev_delta_d;
  logic [1:0]              conf_q, conf_d;
  logic [BA_ADDR_SIZE-1:0] next_pf_addr_q, next_pf_addr_d;
  logic                    ar_valid_q, ar_valid_d;
  logic [BA_ADDR_SIZE-1:0] ar_addr_q, ar_addr_d;
  logic                    q_wr_req_q, q_wr_req_d;
  logic [BA_ADDR_SIZE-1:0] q_addr_q, q_addr_d;
  logic                    flush_q, flush_d;

  logic [BA_ADDR_SIZE-1:0] aligned_addr;
  logic [BA_ADDR_SIZE-1:0] delta;
  logic                    is_match;
  logic                    mismatch_req;
  logic                    handshake;
  logic                    can_issue;

  always_comb begin
    aligned_addr = reqAddr & ALIGN_MASK;
    delta        = aligned_addr - last_addr_q;
    is_match     = (delta == prev_delta_q) && (delta != '0);
    mismatch_req = reqValid && !is_match;
    handshake    = ar_valid_q && arReady;
    can_issue    = !ar_valid_q && (outstandingReqCnt < prefetchWindow) && !almostFull;
  end

  always_comb begin
    state_d        = state_q;
    last_addr_d    = last_addr_q;
    prev_delta_d   = prev_delta_q;
    conf_d         = conf_q;
    next_pf_addr_d = next_pf_addr_q;
    ar_valid_d     = ar_valid_q;
    ar_addr_d      = ar_addr_q;
    q_wr_req_d     = 1'b0;
    q_addr_d       = q_addr_q;
    flush_d        = 1'b0;

    if (handshake) begin
      ar_valid_d     = 1'b0;
      q_wr_req_d     = 1'b1;
      q_addr_d       = ar_addr_q;
      next_pf_addr_d = next_pf_addr_q + prev_delta_q;
    end

    // Stride training runs in every state except IDLE, including DRAIN.
    if (reqValid && (state_q != IDLE)) begin
      last_addr_d = aligned_addr;
      if (is_match) begin
        if (conf_q != 2'd3) conf_d = conf_q + 2'd1;
      end else begin
        conf_d       = '0;
        prev_delta_d = delta;
      end
    end

    case (state_q)
      IDLE: begin
        if (reqValid) begin
          last_addr_d  = aligned_addr;
          prev_delta_d = '0;
          conf_d       = '0;
          state_d      = TRAIN;
        end
      end
      TRAIN: begin
        if (reqValid && is_match && (conf_d >= 2'd2)) begin
          state_d        = ARMED;
          next_pf_addr_d = aligned_addr + delta;
        end
      end
      ARMED: begin
        if (mismatch_req) begin
          // A pending AR must complete before the queue can be flushed.
          if (ar_valid_q) begin
            state_d = DRAIN;
          end else begin
            flush_d = 1'b1;
            state_d = TRAIN;
          end
        end else if (can_issue) begin
          ar_valid_d = 1'b1;
          ar_addr_d  = next_pf_addr_q;
        end
      end
      DRAIN: begin
        // arValid low here means the qWrReq for the last AR is out this cycle.
        if (!ar_valid_q) begin
          flush_d = 1'b1;
          state_d = TRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      last_addr_q    <= '0;
      prev_delta_q   <= '0;
      conf_q         <= '0;
      next_pf_addr_q <= '0;
      ar_valid_q     <= 1'b0;
      ar_addr_q      <= '0;
      q_wr_req_q     <= 1'b0;
      q_addr_q       <= '0;
      flush_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_addr_q    <= last_addr_d;
      prev_delta_q   <= prev_delta_d;
      conf_q         <= conf_d;
      next_pf_addr_q <= next_pf_addr_d;
      ar_valid_q     <= ar_valid_d;
      ar_addr_q      <= ar_addr_d;
      q_wr_req_q     <= q_wr_req_d;
      q_addr_q       <= q_addr_d;
      flush_q        <= flush_d;
    end
  end

  assign arValid   = ar_valid_q;
  assign arAddr    = ar_addr_q;
  assign qWrReq    = q_wr_req_q;
  assign qAddr     = q_addr_q;
  assign flush     = flush_q;
  assign armed     = (state_q == ARMED) || (state_q == DRAIN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prefetcher_addr_gen.sv
// Directed bench for prefetcher_addr_gen: training, AR issue/hold, throttling,
// drain-then-flush, negative-stride wrap and asynchronous reset mid-handshake.
module tb_prefetcher_addr_gen;

  localparam int AW  = 64;
  localparam int LBB = 6;
  localparam int LQS = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRAIN = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic          clk;
  logic          resetN;
  logic          reqValid;
  logic [AW-1:0] reqAddr;
  logic [LQS:0]  outstandingReqCnt;
  logic          almostFull;
  logic [LQS:0]  prefetchWindow;
  logic          arReady;
  logic          arValid;
  logic [AW-1:0] arAddr;
  logic          qWrReq;
  logic [AW-1:0] qAddr;
  logic          flush;
  logic          armed;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];

  prefetcher_addr_gen #(
    .BA_ADDR_SIZE         (AW),
    .LOG_BLOCK_DATA_BYTES (LBB),
    .LOG_QUEUE_SIZE       (LQS)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .reqValid          (reqValid),
    .reqAddr           (reqAddr),
    .outstandingReqCnt (outstandingReqCnt),
    .almostFull        (almostFull),
    .prefetchWindow    (prefetchWindow),
    .arReady           (arReady),
    .arValid           (arValid),
    .arAddr            (arAddr),
    .qWrReq            (qWrReq),
    .qAddr             (qAddr),
    .flush             (flush),
    .armed             (armed),
    .dbg_state         (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [AW-1:0] addr);
    reqValid = 1'b1;
    reqAddr  = addr;
    tick();
    reqValid = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] st, input logic arm);
    chk({tag, "_state"}, AW'(dbg_state), AW'(st));
    chk({tag, "_armed"}, AW'(armed), AW'(arm));
  endtask

  task automatic chk_ar_issue(input string tag, input logic [AW-1:0] addr);
    chk({tag, "_arvalid"}, AW'(arValid), AW'(1'b1));
    chk({tag, "_araddr"}, arAddr, addr);
  endtask

  task automatic chk_ar_idle(input string tag);
    chk({tag, "_arvalid"}, AW'(arValid), AW'(1'b0));
  endtask

  task automatic chk_strobes(input string tag, input logic qwr, input logic fl);
    chk({tag, "_qwrreq"}, AW'(qWrReq), AW'(qwr));
    chk({tag, "_flush"}, AW'(flush), AW'(fl));
  endtask

  // Pops the scoreboard entry and checks the queue write carrying it.
  task automatic expect_qwr(input string tag);
    logic [AW-1:0] e;
    e = exp_q.pop_front();
    chk_strobes(tag, 1'b1, 1'b0);
    chk({tag, "_qaddr"}, qAddr, e);
  endtask

  initial begin
    resetN            = 1'b1;
    reqValid          = 1'b0;
    reqAddr           = '0;
    outstandingReqCnt = '0;
    almostFull        = 1'b0;
    prefetchWindow    = 7'd4;
    arReady           = 1'b1;

    // asynchronous reset before the first clock edge
    #2 resetN = 1'b0;
    #1;
    chk_state("rst", ST_IDLE, 1'b0);
    chk_ar_idle("rst");
    chk("rst_araddr", arAddr, '0);
    chk_strobes("rst", 1'b0, 1'b0);
    chk("rst_qaddr", qAddr, '0);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    // +0x40 stride, first address unaligned (0x1013 -> 0x1000, 0x10FF -> 0x10C0)
    drive_req(64'h1013);
    chk_state("tr1", ST_TRAIN, 1'b0);
    drive_req(64'h1040);
    drive_req(64'h1080);
    chk_state("tr3", ST_TRAIN, 1'b0);
    drive_req(64'h10FF);
    chk_state("tr4", ST_ARMED, 1'b1);
    chk_ar_idle("tr4");
    exp_q.push_back(64'h1100);
    tick();
    chk_ar_issue("iss1", 64'h1100);
    tick();
    expect_qwr("hs1");
    chk_ar_idle("hs1");
    arReady = 1'b0;
    tick();
    chk_ar_issue("iss2", 64'h1140);
    chk_strobes("iss2", 1'b0, 1'b0);

    // AR held stable while arReady is low
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_ar_issue("hold", 64'h1140);
      chk_strobes("hold", 1'b0, 1'b0);
    end
    arReady = 1'b1;
    exp_q.push_back(64'h1140);
    tick();
    expect_qwr("hs2");
    chk_ar_idle("hs2");
    arReady           = 1'b0;
    outstandingReqCnt = 7'd4;

    // throttling by outstanding count, then by almostFull
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ar_idle("thr_cnt");
      chk_strobes("thr_cnt", 1'b0, 1'b0);
    end
    outstandingReqCnt = 7'd0;
    almostFull        = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_ar_idle("thr_af");
    end
    almostFull        = 1'b0;
    outstandingReqCnt = 7'd3;
    tick();
    chk_ar_issue("iss3", 64'h1180);

    // stride break while an AR is pending: drain, queue write, then flush
    drive_req(64'h5000);
    chk_state("drn1", ST_DRAIN, 1'b1);
    chk_ar_issue("drn1", 64'h1180);
    chk_strobes("drn1", 1'b0, 1'b0);
    tick();
    chk_state("drn2", ST_DRAIN, 1'b1);
    chk_ar_issue("drn2", 64'h1180);
    arReady = 1'b1;
    exp_q.push_back(64'h1180);
    tick();
    expect_qwr("drn_hs");
    chk_ar_idle("drn_hs");
    chk_state("drn_hs", ST_DRAIN, 1'b1);
    arReady = 1'b0;
    tick();
    chk_strobes("drn_fl", 1'b0, 1'b1);
    chk_state("drn_fl", ST_TRAIN, 1'b0);
    tick();
    chk_strobes("drn_post", 1'b0, 1'b0);

    // -0x40 stride ending at 0x40: prefetches 0x0 then wrap to top of space
    outstandingReqCnt = 7'd0;
    arReady           = 1'b1;
    drive_req(64'h100);
    drive_req(64'hC0);
    drive_req(64'h80);
    chk_state("neg3", ST_TRAIN, 1'b0);
    drive_req(64'h40);
    chk_state("neg4", ST_ARMED, 1'b1);
    exp_q.push_back(64'h0);
    tick();
    chk_ar_issue("neg_iss1", 64'h0);
    tick();
    expect_qwr("neg_hs1");
    arReady = 1'b0;
    tick();
    chk_ar_issue("neg_wrap", 64'hFFFF_FFFF_FFFF_FFC0);

    // asynchronous reset while an AR is pending
    #2 resetN = 1'b0;
    #1;
    chk_state("mrst", ST_IDLE, 1'b0);
    chk_ar_idle("mrst");
    chk("mrst_araddr", arAddr, '0);
    chk_strobes("mrst", 1'b0, 1'b0);
    chk("mrst_qaddr", qAddr, '0);
    @(negedge clk);
    @(negedge clk);
    resetN  = 1'b1;
    arReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ar_idle("post_rst");
      chk_strobes("post_rst", 1'b0, 1'b0);
      chk_state("post_rst", ST_IDLE, 1'b0);
    end

    // matching demand in ARMED keeps nextPfAddr; mismatch with no pending AR flushes
    outstandingReqCnt = 7'd4;
    arReady           = 1'b0;
    drive_req(64'h2000);
    drive_req(64'h2080);
    drive_req(64'h2100);
    drive_req(64'h2180);
    chk_state("m4", ST_ARMED, 1'b1);
    chk_ar_idle("m4");
    drive_req(64'h2200);
    chk_state("m5", ST_ARMED, 1'b1);
    chk_ar_idle("m5");
    outstandingReqCnt = 7'd0;
    tick();
    chk_ar_issue("m_iss", 64'h2200);
    arReady = 1'b1;
    exp_q.push_back(64'h2200);
    tick();
    expect_qwr("m_hs");
    chk_ar_idle("m_hs");
    arReady = 1'b0;
    drive_req(64'h9000);
    chk_strobes("brk_fl", 1'b0, 1'b1);
    chk_state("brk_fl", ST_TRAIN, 1'b0);
    chk_ar_idle("brk_fl");
    tick();
    chk_strobes("brk_post", 1'b0, 1'b0);
    chk_ar_idle("brk_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
